program_run_controller: RTL



---
 rtl/program_run_controller.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/program_run_controller.sv
// Run controller for the test-program harness: issues one instruction at a time, with free run,
// single-step, halt/resume and step-limit timeout. Optional breakpoint: PROGRAM_RUN_CONTROLLER_BREAKPOINT_EN.
module program_run_controller #(
    parameter int IP_WIDTH   = 12,
    parameter int STEP_WIDTH = 32,
    parameter int MAX_STEPS  = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  step,
    input  logic                  halt,
    output logic                  exec_valid,
    output logic [IP_WIDTH-1:0]   exec_ip,
    input  logic                  exec_ready,
    input  logic                  exec_done,
    input  logic [IP_WIDTH-1:0]   next_ip,
    input  logic                  end_of_program,
    input  logic                  tests_ok,
`ifdef PROGRAM_RUN_CONTROLLER_BREAKPOINT_EN
    input  logic                  bp_en,
    input  logic [IP_WIDTH-1:0]   bp_addr,
    output logic                  bp_hit,
`endif
    output logic                  running,
    output logic                  paused,
    output logic                  finished,
    output logic                  success,
    output logic                  timeout,
    output logic [STEP_WIDTH-1:0] steps
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [STEP_WIDTH-1:0] MAX_STEPS_C = STEP_WIDTH'(MAX_STEPS);

    state_t                  state_r, state_s;
    logic [IP_WIDTH-1:0]     ip_r, ip_s;
    logic [STEP_WIDTH-1:0]   steps_r, steps_s, steps_inc_s;
    logic                    single_r, single_s;
    logic                    halt_pend_r, halt_pend_s;
    logic                    finished_r, finished_s;
    logic                    success_r, success_s;
    logic                    timeout_r, timeout_s;
    logic                    exec_valid_r, running_r, paused_r;
    logic                    complete_s;
`ifdef PROGRAM_RUN_CONTROLLER_BREAKPOINT_EN
    logic                    bp_hit_r, bp_hit_s;
    logic                    bp_skip_r, bp_skip_s;
`endif

    // Next-state logic: control transitions first, then the shared completion rules
    always_comb begin
        state_s     = state_r;
        ip_s        = ip_r;
        steps_s     = steps_r;
        single_s    = single_r;
        halt_pend_s = halt_pend_r;
        finished_s  = finished_r;
        success_s   = success_r;
        timeout_s   = timeout_r;
        steps_inc_s = steps_r + STEP_WIDTH'(1);
        complete_s  = 1'b0;
`ifdef PROGRAM_RUN_CONTROLLER_BREAKPOINT_EN
        bp_hit_s    = bp_hit_r;
        bp_skip_s   = bp_skip_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_ISSUE;
                    ip_s     = {IP_WIDTH{1'b0}};
                    steps_s  = {STEP_WIDTH{1'b0}};
                    single_s = 1'b0;
                end else if (step) begin
                    state_s  = ST_ISSUE;
                    ip_s     = {IP_WIDTH{1'b0}};
                    steps_s  = {STEP_WIDTH{1'b0}};
                    single_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                halt_pend_s = halt_pend_r | halt;
                if (exec_ready && exec_done) begin
                    complete_s = 1'b1;
                end else if (exec_ready) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                halt_pend_s = halt_pend_r | halt;
                if (exec_done) begin
                    complete_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_PAUSED: begin
                // a halt arriving with start/step keeps the controller parked
                if (halt) begin
                    state_s = ST_PAUSED;
                end else if (start) begin
                    state_s  = ST_ISSUE;
                    single_s = 1'b0;
`ifdef PROGRAM_RUN_CONTROLLER_BREAKPOINT_EN
                    bp_hit_s  = 1'b0;
                    bp_skip_s = bp_hit_r;
`endif
                end else if (step) begin
                    state_s  = ST_ISSUE;
                    single_s = 1'b1;
`ifdef PROGRAM_RUN_CONTROLLER_BREAKPOINT_EN
                    bp_hit_s  = 1'b0;
                    bp_skip_s = 1'b0;
`endif
                end else begin
                    state_s = ST_PAUSED;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s    = ST_ISSUE;
                    ip_s       = {IP_WIDTH{1'b0}};
                    steps_s    = {STEP_WIDTH{1'b0}};
                    single_s   = 1'b0;
                    finished_s = 1'b0;
                    success_s  = 1'b0;
                    timeout_s  = 1'b0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (complete_s) begin
            steps_s     = steps_inc_s;
            ip_s        = next_ip;
            halt_pend_s = 1'b0;
`ifdef PROGRAM_RUN_CONTROLLER_BREAKPOINT_EN
            bp_skip_s   = 1'b0;
`endif
            if (end_of_program) begin
                state_s    = ST_DONE;
                finished_s = 1'b1;
                success_s  = tests_ok;
                timeout_s  = 1'b0;
            end else if (steps_inc_s == MAX_STEPS_C) begin
                state_s    = ST_DONE;
                finished_s = 1'b1;
                success_s  = 1'b0;
                timeout_s  = 1'b1;
            end else if (halt_pend_r || halt || single_r) begin
                state_s = ST_PAUSED;
`ifdef PROGRAM_RUN_CONTROLLER_BREAKPOINT_EN
            end else if (bp_en && (next_ip == bp_addr) && !bp_skip_r) begin
                state_s  = ST_PAUSED;
                bp_hit_s = 1'b1;
`endif
            end else begin
                state_s = ST_ISSUE;
            end
        end else begin
            steps_s = steps_s;
        end
    end

    // State registers and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            ip_r         <= {IP_WIDTH{1'b0}};
            steps_r      <= {STEP_WIDTH{1'b0}};
            single_r     <= 1'b0;
            halt_pend_r  <= 1'b0;
            finished_r   <= 1'b0;
            success_r    <= 1'b0;
            timeout_r    <= 1'b0;
            exec_valid_r <= 1'b0;
            running_r    <= 1'b0;
            paused_r     <= 1'b0;
`ifdef PROGRAM_RUN_CONTROLLER_BREAKPOINT_EN
            bp_hit_r     <= 1'b0;
            bp_skip_r    <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            ip_r         <= ip_s;
            steps_r      <= steps_s;
            single_r     <= single_s;
            halt_pend_r  <= halt_pend_s;
            finished_r   <= finished_s;
            success_r    <= success_s;
            timeout_r    <= timeout_s;
            exec_valid_r <= (state_s == ST_ISSUE);
            running_r    <= (state_s == ST_ISSUE) || (state_s == ST_WAIT);
            paused_r     <= (state_s == ST_PAUSED);
`ifdef PROGRAM_RUN_CONTROLLER_BREAKPOINT_EN
            bp_hit_r     <= bp_hit_s;
            bp_skip_r    <= bp_skip_s;
`endif
        end
    end

    assign exec_valid = exec_valid_r;
    assign exec_ip    = ip_r;
    assign running    = running_r;
    assign paused     = paused_r;
    assign finished   = finished_r;
    assign success    = success_r;
    assign timeout    = timeout_r;
    assign steps      = steps_r;
`ifdef PROGRAM_RUN_CONTROLLER_BREAKPOINT_EN
    assign bp_hit     = bp_hit_r;
`endif

endmodule
